// File: rtl/difftest_log_event.sv
// Event statistics logger: accumulates counter deltas and hands out snapshots.
// Define DIFFTEST_LOG_DISPLAY_EN to print one line per completed transfer.
module difftest_log_event #(
  parameter     NAME   = "event",
  parameter int CORE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CORE_W-1:0] coreid,
  input  logic [31:0]       value,
  input  logic              dump_req,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CORE_W-1:0] out_coreid,
  output logic [63:0]       out_total,
  output logic [63:0]       out_cycles,
  output logic [31:0]       out_max_delta
);

  logic [31:0] r_prev;
  logic        r_primed;
  logic [63:0] r_total;
  logic [63:0] r_cycles;
  logic [31:0] r_max_delta;

  logic [31:0] w_delta;
  logic        w_fire;
  logic        w_load;

  assign w_delta = value - r_prev;
  assign w_fire  = out_valid & out_ready;
  assign w_load  = dump_req & (~out_valid | w_fire);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev      <= '0;
      r_primed    <= 1'b0;
      r_total     <= '0;
      r_cycles    <= '0;
      r_max_delta <= '0;
    end else begin
      r_prev   <= value;
      r_primed <= 1'b1;
      if (r_cycles != '1)
        r_cycles <= r_cycles + 64'd1;
      // prev is meaningless until the first post-reset sample lands
      if (r_primed) begin
        r_total <= r_total + {32'd0, w_delta};
        if (w_delta > r_max_delta)
          r_max_delta <= w_delta;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_coreid    <= '0;
      out_total     <= '0;
      out_cycles    <= '0;
      out_max_delta <= '0;
    end else if (w_load) begin
      out_valid     <= 1'b1;
      out_coreid    <= coreid;
      out_total     <= r_total;
      out_cycles    <= r_cycles;
      out_max_delta <= r_max_delta;
    end else if (w_fire) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DIFFTEST_LOG_DISPLAY_EN
  always @(posedge clk) begin
    if (rst && w_fire)
      $display("[%0s] core=%0d total=%0d cycles=%0d max=%0d",
               NAME, out_coreid, out_total, out_cycles,
               out_max_delta);
  end
`else
  logic w_name_unused;
  assign w_name_unused = ^NAME;
`endif

endmodule

// File: tb/tb_difftest_log_event.sv
// Randomized bench for difftest_log_event against a history-based model.
// Directed sequences cover wrap, stall, back-to-back reload and reset.
module tb_difftest_log_event;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] coreid;
  logic [31:0]   value;
  logic          dump_req;
  logic          out_ready;
  logic          out_valid;
  logic [CW-1:0] out_coreid;
  logic [63:0]   out_total;
  logic [63:0]   out_cycles;
  logic [31:0]   out_max_delta;

  always #5 clk = ~clk;

  difftest_log_event #(
    .NAME   ("br"),
    .CORE_W (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .coreid        (coreid),
    .value         (value),
    .dump_req      (dump_req),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_coreid    (out_coreid),
    .out_total     (out_total),
    .out_cycles    (out_cycles),
    .out_max_delta (out_max_delta)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_xfer = 0;

  // every value sampled on a clock edge since reset release
  logic [31:0]   hist[$];
  logic          m_valid;
  logic [CW-1:0] m_core;
  logic [63:0]   m_total;
  logic [63:0]   m_cycles;
  logic [31:0]   m_max;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] f_total();
    logic [63:0] s = '0;
    logic [31:0] d;
    for (int i = 1; i < hist.size(); i++) begin
      d = hist[i] - hist[i-1];
      s = s + {32'd0, d};
    end
    return s;
  endfunction

  function automatic logic [31:0] f_max();
    logic [31:0] m = '0;
    logic [31:0] d;
    for (int i = 1; i < hist.size(); i++) begin
      d = hist[i] - hist[i-1];
      if (d > m) m = d;
    end
    return m;
  endfunction

  task automatic model_clear();
    hist.delete();
    m_valid  = 1'b0;
    m_core   = '0;
    m_total  = '0;
    m_cycles = '0;
    m_max    = '0;
  endtask

  task automatic model_edge();
    bit fire;
    if (!rst) return;
    fire = m_valid && out_ready;
    if (dump_req && (!m_valid || fire)) begin
      m_core   = coreid;
      m_total  = f_total();
      m_cycles = 64'(hist.size());
      m_max    = f_max();
      m_valid  = 1'b1;
    end else if (fire) begin
      m_valid = 1'b0;
    end
    if (fire) n_xfer++;
    hist.push_back(value);
  endtask

  task automatic check_out(string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".core"},  64'(out_coreid), 64'(m_core));
    chk({tag, ".total"}, out_total, m_total);
    chk({tag, ".cyc"},   out_cycles, m_cycles);
    chk({tag, ".max"},   64'(out_max_delta), 64'(m_max));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_out(tag);
  endtask

  task automatic drive(logic d, logic r, logic [31:0] v);
    dump_req  = d;
    out_ready = r;
    value     = v;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_clear();
    check_out("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [63:0] s_total, s_cyc;
  logic [31:0] v;

  initial begin
    rst       = 1'b1;
    coreid    = 8'h00;
    value     = '0;
    dump_req  = 1'b0;
    out_ready = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // counter ramp 10..15 then a dump
    drive(0, 1, 32'd10);
    tick("ramp");
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1, 32'd10 + 32'(i));
      tick("ramp");
    end
    drive(1, 1, 32'd16);
    tick("r029");
    chk("r029_total", out_total, 64'd5);
    chk("r029_max", 64'(out_max_delta), 64'd1);
    chk("r029_valid", 64'(out_valid), 64'd1);
    drive(0, 1, 32'd17);
    tick("r029b");
    chk("r029_drop", 64'(out_valid), 64'd0);

    // wrap yields delta 3
    do_reset();
    drive(0, 0, 32'hFFFF_FFFE);
    tick("wrap");
    drive(0, 0, 32'h0000_0001);
    tick("wrap");
    drive(1, 1, 32'h0000_0001);
    tick("r030");
    chk("r030_total", out_total, 64'd3);
    chk("r030_max", 64'(out_max_delta), 64'd3);
    drive(0, 1, 32'd1);
    tick("r030b");

    // stall with an ignored second request
    coreid = 8'h5A;
    drive(1, 0, 32'd9);
    tick("stall");
    s_total = out_total;
    s_cyc   = out_cycles;
    coreid  = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      drive(i == 1, 0, 32'd20 + 32'(i));
      tick("stall");
      chk("r031_hold_cyc", out_cycles, s_cyc);
      chk("r031_hold_tot", out_total, s_total);
      chk("r031_core", 64'(out_coreid), 64'h5A);
    end
    drive(0, 1, 32'd30);
    tick("stall_xfer");
    chk("r031_done", 64'(out_valid), 64'd0);

    // reload on a completing transfer
    drive(1, 0, 32'd31);
    tick("b2b");
    s_cyc = out_cycles;
    drive(1, 1, 32'd32);
    tick("r032");
    chk("r032_valid", 64'(out_valid), 64'd1);
    chk("r032_cyc", out_cycles, s_cyc + 64'd1);
    drive(0, 1, 32'd33);
    tick("r032b");

    // reset while a snapshot is pending
    drive(1, 0, 32'd40);
    tick("pend");
    chk("r033_pre", 64'(out_valid), 64'd1);
    #2;
    do_reset();
    chk("r033_valid", 64'(out_valid), 64'd0);
    chk("r033_total", out_total, 64'd0);
    drive(1, 1, 32'd7);
    tick("postrst");
    chk("r033_cyc0", out_cycles, 64'd0);

    // random traffic
    v = $urandom;
    for (int i = 0; i < 2000; i++) begin
      coreid = 8'($urandom);
      case ($urandom_range(0, 9))
        0:       v = $urandom;
        1:       v = v - 32'($urandom_range(1, 4));
        default: v = v + 32'($urandom_range(0, 6));
      endcase
      drive($urandom_range(0, 3) == 0,
            $urandom_range(0, 2) != 0, v);
      if ($urandom_range(0, 299) == 0) begin
        @(negedge clk);
        do_reset();
      end else begin
        tick("rand");
      end
    end

    chk("xfers_seen", 64'(n_xfer > 50), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/difftest_log_event.md
DIFFTEST_LOG_EVENT -- requirements
Module: difftest_log_event

Interface
REQ-001 SHALL have parameter NAME, default "event", event label string used in display output.
REQ-002 SHALL have parameter CORE_W, default 8, width of the core identifier.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port coreid, input, CORE_W, identifier of the core that owns the event.
REQ-006 SHALL have port value, input, 32, free-running monotonic event counter sample.
REQ-007 SHALL have port dump_req, input, 1, single-cycle request to snapshot statistics.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts the snapshot.
REQ-009 SHALL have port out_valid, output, 1, snapshot available.
REQ-010 SHALL have port out_coreid, output, CORE_W, coreid captured at snapshot.
REQ-011 SHALL have port out_total, output, 64, accumulated event count.
REQ-012 SHALL have port out_cycles, output, 64, cycles elapsed since reset.
REQ-013 SHALL have port out_max_delta, output, 32, largest single-cycle increment.

Function
REQ-014 SHALL register value into prev every cycle; a primed flag SHALL be set on the first clock edge after reset release.
REQ-015 SHALL compute delta = value - prev modulo 2^32, so a counter wrap from 0xFFFFFFFF to 0x00000002 yields delta 3.
REQ-016 SHALL, when primed, add delta to a 64-bit total each cycle; the first cycle after reset SHALL contribute 0 regardless of value.
REQ-017 SHALL increment a 64-bit cycle counter every cycle after reset, saturating at all-ones.
REQ-018 SHALL, when primed, set max_delta = delta whenever delta > max_delta.
REQ-019 SHALL, on dump_req with out_valid=0, load out_coreid/out_total/out_cycles/out_max_delta from coreid and the internal registers as they stand before that edge's update, and assert out_valid on the next cycle.
REQ-020 SHALL hold all out_* stable while out_valid=1 and out_ready=0.
REQ-021 SHALL complete a transfer on a cycle with out_valid=1 and out_ready=1, and deassert out_valid on the next cycle.
REQ-022 SHALL, when dump_req coincides with a completing transfer, reload the snapshot so out_valid stays 1 with new data.
REQ-023 SHALL ignore dump_req while out_valid=1 and the transfer is not completing.
REQ-024 SHALL leave internal accumulation unaffected by dumps; the statistics are not cleared.

Reset
REQ-025 SHALL, while rst=0, immediately force prev, total, cycles, max_delta, primed, out_valid and all out_* to 0.
REQ-026 SHALL, on reset asserted mid-transfer, drop the pending snapshot without completing it.

Configuration
REQ-027 SHALL, when DIFFTEST_LOG_DISPLAY_EN is defined, print "[NAME] core=<coreid> total=<total> cycles=<cycles> max=<max_delta>" in decimal once per completed transfer.
REQ-028 SHALL, without DIFFTEST_LOG_DISPLAY_EN, produce no simulation output, with port behaviour identical to the defined build.

Verification
REQ-029 SHALL pass this check: reset, then value=10 in the first cycle and +1 per cycle for 5 cycles, then dump_req with out_ready=1 -> out_total=5, out_max_delta=1, out_valid high for exactly one cycle.
REQ-030 SHALL pass this check: value 0xFFFFFFFE then 0x00000001 -> total increases by 3 and max_delta=3.
REQ-031 SHALL pass this check: dump_req with out_ready=0 for 4 cycles, a second dump_req during the stall, then out_ready=1 -> outputs stable during the stall, the second request ignored, one transfer completed.
REQ-032 SHALL pass this check: dump_req asserted in the same cycle as a completing transfer -> out_valid remains 1 and out_cycles is updated to the new snapshot value.
REQ-033 SHALL pass this check: rst driven low while out_valid=1 -> out_valid=0 and all counters=0 immediately, with no display line printed.
REQ-034 SHALL pass this check: with DIFFTEST_LOG_DISPLAY_EN defined and NAME="br", one completed transfer -> exactly one line beginning "[br] core=0".
